// File: rtl/vc_input_port_buffers.sv
// Multi-VC input buffer bank for one router input port: per-VC FWFT FIFO,
// packet FSM (IDLE/VA/SA), write-side protocol checks and credit return.

package vc_input_port_buffers_pkg;
  localparam int DATA_W  = 16;
  localparam int VC_ID_W = 4;

  typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;
  typedef enum logic [2:0] {LOCAL = 3'd0, NORTH = 3'd1, SOUTH = 3'd2, EAST = 3'd3, WEST = 3'd4} port_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_ID_W-1:0]   vc_id;
    logic [DATA_W-1:0]    data;
  } flit_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [DATA_W-1:0]    data;
    port_t                out_port;
  } entry_t;

  typedef enum logic [1:0] {IDLE = 2'd0, VA = 2'd1, SA = 2'd2} vc_state_t;
endpackage

// One virtual channel: FIFO storage, packet FSM and error detection.
// Pops are granted by the parent so that at most one VC pops per cycle.
module vc_input_port_buffers_lane
  import vc_input_port_buffers_pkg::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int VC_SIZE     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_i,
  input  flit_label_t        wr_label_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  input  port_t              wr_port_i,
  input  logic               read_i,
  input  logic               rd_blk_i,
  input  logic               vc_valid_i,
  input  logic [VC_SIZE-1:0] vc_new_i,
  input  logic               pop_i,
  output flit_t              data_o,
  output port_t              out_port_o,
  output logic [VC_SIZE-1:0] downstream_vc_o,
  output logic               vc_request_o,
  output logic               switch_request_o,
  output logic               vc_allocatable_o,
  output logic               is_empty_o,
  output logic               is_full_o,
  output logic               error_o,
  output logic               rd_ok_o,
  output logic               disc_req_o
);
  localparam int            PW       = $clog2(BUFFER_SIZE);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(BUFFER_SIZE);

  entry_t             mem_q [BUFFER_SIZE];
  logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [PW:0]        cnt_q, cnt_d;
  logic               in_pkt_q, in_pkt_d;
  vc_state_t          state_q, state_d;
  port_t              out_port_q;
  logic [VC_SIZE-1:0] dvc_q;
  logic               alloc_q, err_q, err_d;

  entry_t front;
  logic   empty, full, front_head, front_tail;
  logic   wr_lbl_err, wr_full_err, wr_acc;

  assign front      = mem_q[rd_ptr_q];
  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == FULL_CNT);
  assign front_head = (front.flit_label == HEAD) || (front.flit_label == HEADTAIL);
  assign front_tail = (front.flit_label == TAIL) || (front.flit_label == HEADTAIL);

  assign rd_ok_o    = read_i && !rd_blk_i && (state_q == SA) && !empty;
  assign disc_req_o = (state_q == IDLE) && !empty && !front_head;

  // Write acceptance: packet framing check, then room (a same-cycle pop frees a slot)
  always_comb begin
    wr_lbl_err  = wr_i && (((wr_label_i == HEAD) && in_pkt_q) ||
                           (((wr_label_i == BODY) || (wr_label_i == TAIL)) && !in_pkt_q));
    wr_full_err = wr_i && !wr_lbl_err && full && !pop_i;
    wr_acc      = wr_i && !wr_lbl_err && !wr_full_err;
    in_pkt_d    = in_pkt_q;
    if (wr_acc && (wr_label_i == HEAD)) in_pkt_d = 1'b1;
    if (wr_acc && (wr_label_i == TAIL)) in_pkt_d = 1'b0;
    cnt_d = cnt_q;
    if (wr_acc && !pop_i) cnt_d = cnt_q + 1'b1;
    if (!wr_acc && pop_i) cnt_d = cnt_q - 1'b1;
    err_d = wr_lbl_err || wr_full_err || (read_i && !rd_ok_o) ||
            (vc_valid_i && (state_q != VA)) || (pop_i && (state_q == IDLE));
  end

  // FIFO storage (no reset needed: validity is tracked by cnt_q)
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= '{flit_label: wr_label_i, data: wr_data_i, out_port: wr_port_i};
  end

  // FIFO pointers, packet-open flag, error and release pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
      alloc_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q    <= cnt_d;
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
      alloc_q  <= (state_q == SA) && pop_i && front_tail;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: IDLE waits for a head, VA for a grant, SA until the tail pops
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty && front_head) state_d = VA;
      VA:      if (vc_valid_i) state_d = SA;
      SA:      if (pop_i && front_tail) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: allocator requests
  always_comb begin
    vc_request_o     = (state_q == VA);
    switch_request_o = (state_q == SA) && !empty;
  end

  // Route and downstream VC latched on FSM transitions
  always_ff @(posedge clk) begin
    if (rst) begin
      out_port_q <= LOCAL;
      dvc_q      <= '0;
    end else begin
      if ((state_q == IDLE) && !empty && front_head) out_port_q <= front.out_port;
      if ((state_q == VA) && vc_valid_i)             dvc_q      <= vc_new_i;
    end
  end

  assign data_o           = '{flit_label: front.flit_label, vc_id: VC_ID_W'(dvc_q), data: front.data};
  assign out_port_o       = out_port_q;
  assign downstream_vc_o  = dvc_q;
  assign vc_allocatable_o = alloc_q;
  assign is_empty_o       = empty;
  assign is_full_o        = full;
  assign error_o          = err_q;
endmodule

// Top: VC lanes plus read validation, pop arbitration and credit return.
module vc_input_port_buffers
  import vc_input_port_buffers_pkg::*;
#(
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int VC_SIZE     = $clog2(VC_NUM)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  flit_t                           data_i,
  input  logic                            write_i,
  input  port_t                           out_port_i,
  input  logic [VC_NUM-1:0]               read_i,
  input  logic [VC_NUM-1:0]               vc_valid_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]  vc_new_i,
  output flit_t [VC_NUM-1:0]              data_o,
  output port_t [VC_NUM-1:0]              out_port_o,
  output logic [VC_NUM-1:0][VC_SIZE-1:0]  downstream_vc_o,
  output logic [VC_NUM-1:0]               vc_request_o,
  output logic [VC_NUM-1:0]               switch_request_o,
  output logic [VC_NUM-1:0]               vc_allocatable_o,
  output logic                            credit_valid_o,
  output logic [VC_SIZE-1:0]              credit_vc_o,
  output logic [VC_NUM-1:0]               is_empty_o,
  output logic [VC_NUM-1:0]               is_full_o,
  output logic [VC_NUM-1:0]               error_o
);
  logic [VC_NUM-1:0]  rd_ok, disc_req, disc_gnt, pop;
  logic               multi_rd;
  logic [VC_SIZE-1:0] pop_idx;
  logic               credit_valid_q;
  logic [VC_SIZE-1:0] credit_vc_q;

  // A multi-hot switch grant is rejected outright
  assign multi_rd = |(read_i & (read_i - VC_NUM'(1)));

  // Single pop per cycle: a granted read wins; otherwise the lowest IDLE discard
  always_comb begin
    disc_gnt = (|rd_ok) ? '0 : (disc_req & (~disc_req + VC_NUM'(1)));
    pop      = rd_ok | disc_gnt;
    pop_idx  = '0;
    for (int v = 0; v < VC_NUM; v++) if (pop[v]) pop_idx = VC_SIZE'(v);
  end

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    vc_input_port_buffers_lane #(.BUFFER_SIZE(BUFFER_SIZE), .VC_SIZE(VC_SIZE)) u_lane (
      .clk              (clk),
      .rst              (rst),
      .wr_i             (write_i && (data_i.vc_id == VC_ID_W'(v))),
      .wr_label_i       (data_i.flit_label),
      .wr_data_i        (data_i.data),
      .wr_port_i        (out_port_i),
      .read_i           (read_i[v]),
      .rd_blk_i         (multi_rd),
      .vc_valid_i       (vc_valid_i[v]),
      .vc_new_i         (vc_new_i[v]),
      .pop_i            (pop[v]),
      .data_o           (data_o[v]),
      .out_port_o       (out_port_o[v]),
      .downstream_vc_o  (downstream_vc_o[v]),
      .vc_request_o     (vc_request_o[v]),
      .switch_request_o (switch_request_o[v]),
      .vc_allocatable_o (vc_allocatable_o[v]),
      .is_empty_o       (is_empty_o[v]),
      .is_full_o        (is_full_o[v]),
      .error_o          (error_o[v]),
      .rd_ok_o          (rd_ok[v]),
      .disc_req_o       (disc_req[v])
    );
  end

  // Credit strobe for the slot freed by this cycle's pop
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
    end else begin
      credit_valid_q <= |pop;
      credit_vc_q    <= pop_idx;
    end
  end

  assign credit_valid_o = credit_valid_q;
  assign credit_vc_o    = credit_vc_q;
endmodule

// File: tb/tb_vc_input_port_buffers.sv
// Directed bench for vc_input_port_buffers (VC_NUM=2, BUFFER_SIZE=8).
module tb_vc_input_port_buffers;
  import vc_input_port_buffers_pkg::*;

  localparam int VC_NUM  = 2;
  localparam int VC_SIZE = 1;

  logic                           clk = 1'b0;
  logic                           rst;
  flit_t                          data_i;
  logic                           write_i;
  port_t                          out_port_i;
  logic [VC_NUM-1:0]              read_i;
  logic [VC_NUM-1:0]              vc_valid_i;
  logic [VC_NUM-1:0][VC_SIZE-1:0] vc_new_i;
  flit_t [VC_NUM-1:0]             data_o;
  port_t [VC_NUM-1:0]             out_port_o;
  logic [VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_o;
  logic [VC_NUM-1:0]              vc_request_o, switch_request_o, vc_allocatable_o;
  logic                           credit_valid_o;
  logic [VC_SIZE-1:0]             credit_vc_o;
  logic [VC_NUM-1:0]              is_empty_o, is_full_o, error_o;

  int checks = 0;
  int failures = 0;

  vc_input_port_buffers #(.VC_NUM(VC_NUM), .BUFFER_SIZE(8)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .write_i(write_i), .out_port_i(out_port_i),
    .read_i(read_i), .vc_valid_i(vc_valid_i), .vc_new_i(vc_new_i), .data_o(data_o),
    .out_port_o(out_port_o), .downstream_vc_o(downstream_vc_o), .vc_request_o(vc_request_o),
    .switch_request_o(switch_request_o), .vc_allocatable_o(vc_allocatable_o),
    .credit_valid_o(credit_valid_o), .credit_vc_o(credit_vc_o), .is_empty_o(is_empty_o),
    .is_full_o(is_full_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    flit_label_t lbl;
    logic [15:0] d;
    port_t       port;
    logic [1:0]  rd;
    logic [1:0]  vv;
    logic [1:0]  vnew;
    logic        e_empty0;
    logic        e_vreq0;
    logic        e_sreq0;
    logic        e_cv;
    logic        e_alloc0;
    logic [1:0]  e_err;
    logic        chk_d;
    logic [15:0] e_d;
    logic [3:0]  e_vcid;
    port_t       e_port;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    write_i    = 1'b0;
    read_i     = '0;
    vc_valid_i = '0;
    vc_new_i   = '0;
    data_i     = '0;
    out_port_i = LOCAL;
  endtask

  task automatic wr(input int vc, input flit_label_t l, input logic [15:0] d, input port_t p);
    write_i    = 1'b1;
    data_i     = '{flit_label: l, vc_id: 4'(vc), data: d};
    out_port_i = p;
  endtask

  task automatic do_reset;
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // single packet on VC0: HEAD/BODY/TAIL, grant to downstream VC 1, three reads
    //          wr   lbl       d        port   rd     vv     vnew   emp vrq srq cv al  err   chkd e_d      vcid e_port
    tbl[0] = '{1'b1, HEAD,     16'hA1, NORTH, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 16'hA1, 4'd0, LOCAL};
    tbl[1] = '{1'b1, BODY,     16'hA2, NORTH, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 0, 2'b00, 1, 16'hA1, 4'd0, NORTH};
    tbl[2] = '{1'b1, TAIL,     16'hA3, NORTH, 2'b00, 2'b01, 2'b01, 0, 0, 1, 0, 0, 2'b00, 1, 16'hA1, 4'd1, NORTH};
    tbl[3] = '{1'b0, HEAD,     16'h00, LOCAL, 2'b01, 2'b00, 2'b00, 0, 0, 1, 1, 0, 2'b00, 1, 16'hA2, 4'd1, NORTH};
    tbl[4] = '{1'b0, HEAD,     16'h00, LOCAL, 2'b01, 2'b00, 2'b00, 0, 0, 1, 1, 0, 2'b00, 1, 16'hA3, 4'd1, NORTH};
    tbl[5] = '{1'b0, HEAD,     16'h00, LOCAL, 2'b01, 2'b00, 2'b00, 1, 0, 0, 1, 1, 2'b00, 0, 16'h00, 4'd0, NORTH};
    tbl[6] = '{1'b0, HEAD,     16'h00, LOCAL, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0, 16'h00, 4'd0, NORTH};

    // reset state
    do_reset();
    chk("rst_empty", 32'(is_empty_o), 32'h3);
    chk("rst_full", 32'(is_full_o), 32'h0);
    chk("rst_port0", 32'(out_port_o[0]), 32'(LOCAL));
    chk("rst_port1", 32'(out_port_o[1]), 32'(LOCAL));
    chk("rst_dvc", 32'(downstream_vc_o), 32'h0);
    chk("rst_vreq", 32'(vc_request_o), 32'h0);
    chk("rst_sreq", 32'(switch_request_o), 32'h0);
    chk("rst_alloc", 32'(vc_allocatable_o), 32'h0);
    chk("rst_credit", 32'(credit_valid_o), 32'h0);
    chk("rst_err", 32'(error_o), 32'h0);

    for (int i = 0; i < 7; i++) begin
      idle_in();
      if (tbl[i].wr) wr(0, tbl[i].lbl, tbl[i].d, tbl[i].port);
      read_i     = tbl[i].rd;
      vc_valid_i = tbl[i].vv;
      vc_new_i   = tbl[i].vnew;
      tick();
      chk($sformatf("pkt%0d_empty0", i), 32'(is_empty_o[0]), 32'(tbl[i].e_empty0));
      chk($sformatf("pkt%0d_vreq0", i), 32'(vc_request_o[0]), 32'(tbl[i].e_vreq0));
      chk($sformatf("pkt%0d_sreq0", i), 32'(switch_request_o[0]), 32'(tbl[i].e_sreq0));
      chk($sformatf("pkt%0d_credit", i), 32'(credit_valid_o), 32'(tbl[i].e_cv));
      if (tbl[i].e_cv) chk($sformatf("pkt%0d_credit_vc", i), 32'(credit_vc_o), 32'h0);
      chk($sformatf("pkt%0d_alloc0", i), 32'(vc_allocatable_o[0]), 32'(tbl[i].e_alloc0));
      chk($sformatf("pkt%0d_err", i), 32'(error_o), 32'(tbl[i].e_err));
      chk($sformatf("pkt%0d_port0", i), 32'(out_port_o[0]), 32'(tbl[i].e_port));
      if (tbl[i].chk_d) begin
        chk($sformatf("pkt%0d_data0", i), 32'(data_o[0].data), 32'(tbl[i].e_d));
        chk($sformatf("pkt%0d_vcid0", i), 32'(data_o[0].vc_id), 32'(tbl[i].e_vcid));
      end
    end
    idle_in();

    // fill VC1 to capacity, overflow write dropped, then write+read when full
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr(1, (i == 0) ? HEAD : BODY, 16'h100 + 16'(i), NORTH);
      tick();
    end
    idle_in();
    chk("fill_full1", 32'(is_full_o[1]), 32'h1);
    chk("fill_vreq1", 32'(vc_request_o[1]), 32'h1);
    wr(1, BODY, 16'h1FF, NORTH);
    tick();
    idle_in();
    chk("ovf_err", 32'(error_o), 32'h2);
    chk("ovf_full1", 32'(is_full_o[1]), 32'h1);
    tick();
    chk("ovf_err_clear", 32'(error_o), 32'h0);
    vc_valid_i = 2'b10;
    tick();
    idle_in();
    chk("fill_sreq1", 32'(switch_request_o[1]), 32'h1);
    wr(1, BODY, 16'h108, NORTH);
    read_i = 2'b10;
    tick();
    idle_in();
    chk("wr_rd_full1", 32'(is_full_o[1]), 32'h1);
    chk("wr_rd_err", 32'(error_o), 32'h0);
    chk("wr_rd_credit", 32'(credit_valid_o), 32'h1);
    chk("wr_rd_credit_vc", 32'(credit_vc_o), 32'h1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_data1", k), 32'(data_o[1].data), 32'h101 + 32'(k));
      read_i = 2'b10;
      tick();
      read_i = 2'b00;
    end
    chk("drain_empty1", 32'(is_empty_o[1]), 32'h1);

    // back-to-back HEADTAIL packets on VC0
    do_reset();
    wr(0, HEADTAIL, 16'h21, EAST);
    tick();
    wr(0, HEADTAIL, 16'h22, WEST);
    tick();
    idle_in();
    chk("b2b_vreq0", 32'(vc_request_o[0]), 32'h1);
    chk("b2b_port_east", 32'(out_port_o[0]), 32'(EAST));
    vc_valid_i = 2'b01;
    tick();
    idle_in();
    read_i = 2'b01;
    tick();
    idle_in();
    chk("b2b_idle_vreq0", 32'(vc_request_o[0]), 32'h0);
    chk("b2b_idle_sreq0", 32'(switch_request_o[0]), 32'h0);
    chk("b2b_alloc0", 32'(vc_allocatable_o[0]), 32'h1);
    chk("b2b_credit", 32'(credit_valid_o), 32'h1);
    tick();
    chk("b2b_va_vreq0", 32'(vc_request_o[0]), 32'h1);
    chk("b2b_port_west", 32'(out_port_o[0]), 32'(WEST));
    chk("b2b_alloc0_clear", 32'(vc_allocatable_o[0]), 32'h0);

    // interleaved VCs plus a multi-hot read that must be rejected
    do_reset();
    wr(0, HEAD, 16'h30, SOUTH); tick();
    wr(1, HEAD, 16'h40, EAST);  tick();
    wr(0, TAIL, 16'h31, SOUTH); tick();
    wr(1, TAIL, 16'h41, EAST);  tick();
    idle_in();
    chk("il_vreq", 32'(vc_request_o), 32'h3);
    vc_valid_i = 2'b11;
    vc_new_i   = 2'b01;
    tick();
    idle_in();
    chk("il_sreq", 32'(switch_request_o), 32'h3);
    chk("il_port0", 32'(out_port_o[0]), 32'(SOUTH));
    chk("il_port1", 32'(out_port_o[1]), 32'(EAST));
    read_i = 2'b11;
    tick();
    idle_in();
    chk("multi_err", 32'(error_o), 32'h3);
    chk("multi_credit", 32'(credit_valid_o), 32'h0);
    chk("multi_data0", 32'(data_o[0].data), 32'h30);
    chk("multi_data1", 32'(data_o[1].data), 32'h40);
    chk("il_vcid0", 32'(data_o[0].vc_id), 32'h1);
    chk("il_vcid1", 32'(data_o[1].vc_id), 32'h0);
    read_i = 2'b01; tick(); idle_in();
    chk("il_r1_credit", 32'(credit_valid_o), 32'h1);
    chk("il_r1_vc", 32'(credit_vc_o), 32'h0);
    chk("il_r1_data0", 32'(data_o[0].data), 32'h31);
    read_i = 2'b10; tick(); idle_in();
    chk("il_r2_credit", 32'(credit_valid_o), 32'h1);
    chk("il_r2_vc", 32'(credit_vc_o), 32'h1);
    chk("il_r2_data1", 32'(data_o[1].data), 32'h41);
    read_i = 2'b01; tick(); idle_in();
    chk("il_r3_vc", 32'(credit_vc_o), 32'h0);
    chk("il_r3_alloc", 32'(vc_allocatable_o), 32'h1);
    chk("il_r3_empty0", 32'(is_empty_o[0]), 32'h1);
    read_i = 2'b10; tick(); idle_in();
    chk("il_r4_credit", 32'(credit_valid_o), 32'h1);
    chk("il_r4_vc", 32'(credit_vc_o), 32'h1);
    chk("il_r4_alloc", 32'(vc_allocatable_o), 32'h2);
    chk("il_r4_empty", 32'(is_empty_o), 32'h3);

    // framing errors and stray grants
    do_reset();
    wr(0, BODY, 16'h55, NORTH);
    tick();
    idle_in();
    chk("body_err", 32'(error_o), 32'h1);
    chk("body_dropped", 32'(is_empty_o[0]), 32'h1);
    tick();
    chk("body_err_clear", 32'(error_o), 32'h0);
    vc_valid_i = 2'b01;
    vc_new_i   = 2'b01;
    tick();
    idle_in();
    chk("stray_vv_err", 32'(error_o), 32'h1);
    chk("stray_vv_dvc", 32'(downstream_vc_o), 32'h0);
    read_i = 2'b10;
    tick();
    idle_in();
    chk("idle_rd_err", 32'(error_o), 32'h2);
    chk("idle_rd_credit", 32'(credit_valid_o), 32'h0);

    // reset with a packet in flight
    do_reset();
    wr(0, HEAD, 16'h70, WEST); tick();
    wr(0, BODY, 16'h71, WEST); tick();
    wr(0, BODY, 16'h72, WEST); tick();
    idle_in();
    chk("mid_pre_empty0", 32'(is_empty_o[0]), 32'h0);
    rst = 1'b1;
    tick();
    chk("mid_rst_empty", 32'(is_empty_o), 32'h3);
    chk("mid_rst_vreq", 32'(vc_request_o), 32'h0);
    chk("mid_rst_port0", 32'(out_port_o[0]), 32'(LOCAL));
    chk("mid_rst_credit", 32'(credit_valid_o), 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_post_credit", 32'(credit_valid_o), 32'h0);
    chk("mid_post_empty", 32'(is_empty_o), 32'h3);
    chk("mid_post_vreq", 32'(vc_request_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
